// File: rtl/adder_selftest_ctrl.sv
// Self-test sequencer for the W-bit ripple adder: drives operand pairs, checks sum and sig,
// reports errors. Define SELFTEST_CORNER_EN to prepend five directed corner vectors.
module adder_selftest_ctrl #(
  parameter int unsigned W       = 32,
  parameter int unsigned NUM_VEC = 256,
  parameter int unsigned SETTLE  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] s,
  input  logic         sig,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_cnt,
  output logic [W-1:0] fail_a,
  output logic [W-1:0] fail_b,
  output logic [W-1:0] fail_s
);

`ifdef SELFTEST_CORNER_EN
  localparam int unsigned NumCorner = 5;
`else
  localparam int unsigned NumCorner = 0;
`endif
  localparam int unsigned Total      = NUM_VEC + NumCorner;
  localparam logic [W-1:0] Poly      = W'(32'h80200003);
  localparam logic [3:0]   SettleInit = 4'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StCheck, StDone} state_e;

  state_e       r_state, w_state_next;
  logic [W-1:0] r_lfsr_a, w_lfsr_a_next, r_lfsr_b, w_lfsr_b_next;
  logic [W-1:0] r_a, w_a_next, r_b, w_b_next;
  logic [W-1:0] r_fail_a, w_fail_a_next, r_fail_b, w_fail_b_next, r_fail_s, w_fail_s_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic [31:0]  r_vec, w_vec_next, w_vec_inc;
  logic [15:0]  r_err, w_err_next, w_err_inc;
  logic         r_pass, w_pass_next;
  logic [W-1:0] w_sum;
  logic         w_fail;
  logic         w_corner;
  logic [W-1:0] w_corner_a, w_corner_b;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] l);
    return (l >> 1) ^ (l[0] ? Poly : '0);
  endfunction

`ifdef SELFTEST_CORNER_EN
  assign w_corner = (r_vec < 32'd5);
  always_comb begin
    w_corner_a = '0;
    w_corner_b = '0;
    case (r_vec[2:0])
      3'd1: begin w_corner_a = '1; w_corner_b = W'(1); end
      3'd2: begin w_corner_a = '1; w_corner_b = '1; end
      3'd3: begin w_corner_a = {1'b0, {(W-1){1'b1}}}; w_corner_b = W'(1); end
      3'd4: begin w_corner_a = {(W/2){2'b10}}; w_corner_b = {(W/2){2'b01}}; end
      default: ;
    endcase
  end
`else
  assign w_corner   = 1'b0;
  assign w_corner_a = '0;
  assign w_corner_b = '0;
`endif

  assign w_sum     = r_a + r_b;
  assign w_fail    = !sig || (s != w_sum);
  assign w_err_inc = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
  assign w_vec_inc = r_vec + 32'd1;

  always_comb begin
    w_state_next  = r_state;
    w_lfsr_a_next = r_lfsr_a;
    w_lfsr_b_next = r_lfsr_b;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_fail_a_next = r_fail_a;
    w_fail_b_next = r_fail_b;
    w_fail_s_next = r_fail_s;
    w_cnt_next    = r_cnt;
    w_vec_next    = r_vec;
    w_err_next    = r_err;
    w_pass_next   = r_pass;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_lfsr_a_next = (seed == '0) ? W'(1) : seed;
          w_lfsr_b_next = (~seed == '0) ? W'(1) : ~seed;
          w_fail_a_next = '0;
          w_fail_b_next = '0;
          w_fail_s_next = '0;
          w_err_next    = '0;
          w_pass_next   = 1'b0;
          w_vec_next    = '0;
          w_state_next  = (Total == 0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        w_a_next     = w_corner ? w_corner_a : r_lfsr_a;
        w_b_next     = w_corner ? w_corner_b : r_lfsr_b;
        w_cnt_next   = SettleInit;
        w_state_next = StSettle;
      end
      StSettle: begin
        if (r_cnt == 4'd0) w_state_next = StCheck;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      StCheck: begin
        if (w_fail) begin
          w_err_next = w_err_inc;
          if (r_err == 16'd0) begin
            w_fail_a_next = r_a;
            w_fail_b_next = r_b;
            w_fail_s_next = s;
          end
        end
        // Corner vectors leave the random sequence untouched.
        if (!w_corner) begin
          w_lfsr_a_next = lfsr_step(r_lfsr_a);
          w_lfsr_b_next = lfsr_step(r_lfsr_b);
        end
        w_vec_next   = w_vec_inc;
        w_state_next = (w_vec_inc == Total) ? StDone : StLoad;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (w_state_next == StDone && r_state != StDone) w_pass_next = (w_err_next == 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_lfsr_a <= '0;
      r_lfsr_b <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_fail_a <= '0;
      r_fail_b <= '0;
      r_fail_s <= '0;
      r_cnt    <= '0;
      r_vec    <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_lfsr_a <= w_lfsr_a_next;
      r_lfsr_b <= w_lfsr_b_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_fail_a <= w_fail_a_next;
      r_fail_b <= w_fail_b_next;
      r_fail_s <= w_fail_s_next;
      r_cnt    <= w_cnt_next;
      r_vec    <= w_vec_next;
      r_err    <= w_err_next;
      r_pass   <= w_pass_next;
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign busy    = (r_state == StLoad) || (r_state == StSettle) || (r_state == StCheck);
  assign done    = (r_state == StDone);
  assign pass    = r_pass;
  assign err_cnt = r_err;
  assign fail_a  = r_fail_a;
  assign fail_b  = r_fail_b;
  assign fail_s  = r_fail_s;

endmodule

// File: tb/tb_adder_selftest_ctrl.sv
// Scoreboard bench for adder_selftest_ctrl: the bench plays the adder (with injectable faults),
// queues hand-computed operand pairs and run results, and a monitor compares them.
module tb_adder_selftest_ctrl;
  localparam int unsigned W      = 32;
  localparam int unsigned NumVec = 4;
  localparam int unsigned Settle = 2;
  localparam int unsigned Per    = Settle + 2;
`ifdef SELFTEST_CORNER_EN
  localparam int unsigned NumCorner = 5;
  localparam logic [15:0] StuckErr = 16'd5;
  localparam logic [31:0] StuckFa  = 32'hFFFFFFFF;
  localparam logic [31:0] StuckFb  = 32'hFFFFFFFF;
  localparam logic [31:0] StuckFs  = 32'hFFFFFFDE;
`else
  localparam int unsigned NumCorner = 0;
  localparam logic [15:0] StuckErr = 16'd3;
  localparam logic [31:0] StuckFa  = 32'h00000001;
  localparam logic [31:0] StuckFb  = 32'hFFFFFFFE;
  localparam logic [31:0] StuckFs  = 32'hFFFFFFDF;
`endif
  localparam int unsigned Total    = NumVec + NumCorner;
  localparam int unsigned RunEdges = Total * Per;

  typedef struct {
    logic [15:0] err;
    logic [31:0] fa, fb, fs;
    logic        pass;
    int unsigned cyc;
  } res_t;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [W-1:0] seed = '0;
  logic [W-1:0] a, b, s, w_true;
  logic         sig, busy, done, pass;
  logic [15:0]  err_cnt;
  logic [W-1:0] fail_a, fail_b, fail_s;
  logic         stuck5 = 1'b0, sig_fault = 1'b0;

  int unsigned  n_vec = 0, n_miss = 0, cyc = 0, mon_k = 0, busy_cnt = 0;
  logic [63:0]  op_q[$];
  res_t         res_q[$];

  // Operand pairs {a,b} from hand-stepped Galois LFSRs for seed 1 and seed 0.
  logic [63:0] ops_s1[4] = '{64'h00000001_FFFFFFFE, 64'h80200003_7FFFFFFF,
                             64'hC0300002_BFDFFFFC, 64'h60180001_5FEFFFFE};
  logic [63:0] ops_s0[4] = '{64'h00000001_FFFFFFFF, 64'h80200003_FFDFFFFC,
                             64'hC0300002_7FEFFFFE, 64'h60180001_3FF7FFFF};
`ifdef SELFTEST_CORNER_EN
  logic [63:0] corner_ops[5] = '{64'h00000000_00000000, 64'hFFFFFFFF_00000001,
                                 64'hFFFFFFFF_FFFFFFFF, 64'h7FFFFFFF_00000001,
                                 64'hAAAAAAAA_55555555};
`endif

  assign w_true = a + b;
  assign s      = stuck5 ? (w_true & ~32'h20) : w_true;
  assign sig    = (s == w_true) && !(sig_fault && a == 32'h80200003);

  adder_selftest_ctrl #(.W(W), .NUM_VEC(NumVec), .SETTLE(Settle)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .a(a), .b(b), .s(s), .sig(sig),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_a(fail_a), .fail_b(fail_b), .fail_s(fail_s)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_ops(input bit tbl0);
`ifdef SELFTEST_CORNER_EN
    for (int i = 0; i < 5; i++) op_q.push_back(corner_ops[i]);
`endif
    for (int i = 0; i < 4; i++) op_q.push_back(tbl0 ? ops_s0[i] : ops_s1[i]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(RunEdges) + 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("done_timeout");
  endtask

  task automatic run_once(input logic [31:0] sd, input bit tbl0, input logic [15:0] e,
                          input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fs,
                          input logic p);
    res_t r;
    bit   ok;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    r.err = e; r.fa = fa; r.fb = fb; r.fs = fs; r.pass = p;
    // Accepting edge is cyc+1; done shows after RunEdges more edges (start cycle + vectors + DONE).
    r.cyc = cyc + 1 + RunEdges;
    push_ops(tbl0);
    res_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      chk("pass_hold", {63'd0, pass}, {63'd0, p});
      chk("err_hold", {48'd0, err_cnt}, {48'd0, e});
    end
  endtask

  // Monitor: operands checked in each vector's CHECK cycle, run results on the done pulse.
  initial forever begin
    logic [63:0] exp_op;
    res_t        r;
    @(negedge clk);
    if (busy) begin
      if (mon_k % Per == Per - 1) begin
        if (op_q.size() == 0) flag("unexpected_vector");
        else begin
          exp_op = op_q.pop_front();
          chk("operands", {a, b}, exp_op);
        end
      end
      mon_k++;
      busy_cnt++;
    end
    if (done) begin
      if (res_q.size() == 0) flag("unexpected_done");
      else begin
        r = res_q.pop_front();
        chk("err_cnt", {48'd0, err_cnt}, {48'd0, r.err});
        chk("fail_a", {32'd0, fail_a}, {32'd0, r.fa});
        chk("fail_b", {32'd0, fail_b}, {32'd0, r.fb});
        chk("fail_s", {32'd0, fail_s}, {32'd0, r.fs});
        chk("pass", {63'd0, pass}, {63'd0, r.pass});
        chk("done_cycle", 64'(cyc), 64'(r.cyc));
        chk("busy_cycles", 64'(busy_cnt), 64'(RunEdges));
        chk("busy_in_done", {63'd0, busy}, 64'd0);
      end
      mon_k    = 0;
      busy_cnt = 0;
    end
  end

  initial begin
    res_t r1, r2;
    bit   ok;
    int   n;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a", {32'd0, a}, 64'd0);
    chk("rst_b", {32'd0, b}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, pass}, 64'd0);
    chk("rst_err", {48'd0, err_cnt}, 64'd0);
    rst = 1'b0;

    run_once(32'h1, 1'b0, 16'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    stuck5 = 1'b1;
    run_once(32'h1, 1'b0, StuckErr, StuckFa, StuckFb, StuckFs, 1'b0);
    stuck5 = 1'b0;
    run_once(32'h0, 1'b1, 16'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    sig_fault = 1'b1;
    run_once(32'h1, 1'b0, 16'd1, 32'h80200003, 32'h7FFFFFFF, 32'h00200002, 1'b0);
    sig_fault = 1'b0;

    // Reset in the first SETTLE cycle of vector 3, with a failure already recorded.
    stuck5 = 1'b1;
    @(negedge clk);
    seed  = 32'h1;
    start = 1'b1;
    push_ops(1'b0);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    for (int i = 0; i < 200 && n < int'(2 * Per + 2); i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    #1 rst = 1'b1;
    op_q.delete();
    res_q.delete();
    mon_k    = 0;
    busy_cnt = 0;
    #1;
    chk("midrst_a", {32'd0, a}, 64'd0);
    chk("midrst_b", {32'd0, b}, 64'd0);
    chk("midrst_flags", {61'd0, busy, done, pass}, 64'd0);
    chk("midrst_err", {48'd0, err_cnt}, 64'd0);
    chk("midrst_fail", {fail_a, fail_b}, 64'd0);
    chk("midrst_fail_s", {32'd0, fail_s}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    stuck5 = 1'b0;
    repeat (RunEdges + 4) @(negedge clk);
    chk("no_resume", {62'd0, busy, done}, 64'd0);
    run_once(32'h1, 1'b0, 16'd0, 32'd0, 32'd0, 32'd0, 1'b1);

    // start held high: one run per IDLE visit, second accepted two edges after the first done.
    @(negedge clk);
    seed  = 32'h0;
    start = 1'b1;
    r1.err = 16'd0; r1.fa = '0; r1.fb = '0; r1.fs = '0; r1.pass = 1'b1;
    r2     = r1;
    r1.cyc = cyc + 1 + RunEdges;
    r2.cyc = cyc + 1 + 2 * RunEdges + 2;
    push_ops(1'b1);
    push_ops(1'b1);
    res_q.push_back(r1);
    res_q.push_back(r2);
    wait_done(ok);
    if (ok) wait_done(ok);
    start = 1'b0;
    repeat (2 * Per) @(negedge clk);
    chk("no_third_run", {63'd0, busy}, 64'd0);
    chk("runs_left", 64'(res_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adder_selftest_ctrl.md
Name: adder_selftest_ctrl

Overview:
- Self-test sequencer that sits directly around the 32-bit ripple adder stage.
- Upstream role: generates operand pairs and drives them onto the adder's a/b inputs.
- Downstream role: waits for the ripple carry to settle, samples the adder's s and sig outputs, and checks them against an internal golden sum.
- Reports error count, first-failure capture and pass/done status to the test harness.

Parameters:
- W, 32, operand/sum width; must match the adder width.
- NUM_VEC, 256, number of pseudo-random vectors per run (0 allowed).
- SETTLE, 2, clock cycles operands are held before sampling (1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- seed  in  W  LFSR seed, latched on an accepted start.
- a  out  W  operand A to the adder.
- b  out  W  operand B to the adder.
- s  in  W  ripple sum from the adder.
- sig  in  1  adder self-match flag (1 = ripple sum equals behavioural sum).
- busy  out  1  high from LOAD through CHECK.
- done  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  high when the last run finished with err_cnt==0; held until the next accepted start.
- err_cnt  out  16  failing vectors in the current run; saturates at 16'hFFFF.
- fail_a, fail_b, fail_s  out  W each  operands and sum of the first failing vector.

Behaviour:
- Reset (async, immediate) clears all outputs and state to 0: a=b=0, busy=done=pass=0, err_cnt=0, fail_*=0, FSM=IDLE. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
- IDLE:
  - start=1: latch lfsr_a = (seed==0 ? 32'h1 : seed) and lfsr_b = ~seed (if ~seed==0, use 32'h1); clear err_cnt, fail_*, pass; go to LOAD.
  - NUM_VEC==0 (and no corner vectors): go straight to DONE instead.
- LOAD (1 cycle): a <= lfsr_a, b <= lfsr_b; settle counter <= SETTLE-1; go to SETTLE.
- SETTLE: decrement the counter; go to CHECK when it reaches 0. a and b are stable for SETTLE full cycles before sampling.
- CHECK (1 cycle):
  - fail = !sig || (s != a+b), sum taken mod 2^W.
  - On fail: err_cnt increments (saturating); if this is the first failure of the run, capture a, b, s into fail_a/fail_b/fail_s.
  - Advance both LFSRs one Galois step: next = (l>>1) ^ (l[0] ? 32'h80200003 : 0).
  - Vector counter increments; if the count equals the total, go to DONE, else go to LOAD.
- DONE (1 cycle): done=1, pass=(err_cnt==0), busy=0; go to IDLE. a/b hold the last vector.
- Per-vector latency = SETTLE+2 cycles. Run length = total*(SETTLE+2) + 2 cycles from the start sample to the done pulse.
- start while not in IDLE is ignored. start in the same cycle that DONE returns to IDLE is not accepted; it must be sampled in IDLE.
- err_cnt and fail_* remain valid after done until the next accepted start.

Optional Feature:
- Macro SELFTEST_CORNER_EN.
- Defined: five directed vectors run before the random ones, in this order: (0,0), (FFFFFFFF,1), (FFFFFFFF,FFFFFFFF), (7FFFFFFF,1), (AAAAAAAA,55555555). LFSRs do not step during the corner vectors. Total vectors = NUM_VEC+5.
- Undefined: random vectors only; total = NUM_VEC.

Test Plan:
- Correct adder, SETTLE=2, NUM_VEC=4, seed=32'h1, start pulse -> busy high for 16 cycles, done pulse 18 cycles after start, pass=1, err_cnt=0.
- Adder with s[5] stuck at 0, NUM_VEC=256 -> err_cnt>0; fail_a/fail_b equal the first vector whose true sum bit 5 = 1; fail_s[5]=0; pass=0.
- seed=0 -> first a=32'h00000001, b=32'hFFFFFFFF; a correct adder gives s=0 and no error.
- Assert rst during SETTLE of vector 3 -> all outputs 0 on the same edge, no done pulse; a following start runs a full clean run.
- start held high through a whole run -> exactly one run per IDLE visit; a second run begins only after IDLE is re-entered.
- With SELFTEST_CORNER_EN, NUM_VEC=0 -> 5 vectors checked; the (FFFFFFFF,FFFFFFFF) vector expects s=FFFFFFFE; done after 5*(SETTLE+2)+2 cycles; pass=1.
